// File: rtl/mac_sequencer.sv
// Sequences one MAC lane through clear / accumulate / capture and turns the
// 17-bit accumulated sum into a biased, optionally rectified, shifted int8.
module mac_sequencer #(
   parameter int KERNEL_LEN = 9,
   parameter int SHIFT      = 4,
   parameter bit RELU_EN    = 1'b1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_data,
   input  logic [7:0]  in_weight,
   input  logic [16:0] bias,
   output logic [7:0]  mac_data,
   output logic [7:0]  mac_weight,
   output logic        mac_enable,
   output logic        mac_reset,
   input  logic [16:0] mac_result,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [7:0]  out_data,
   output logic        busy
);

   typedef enum logic [1:0] {
      ST_CLEAR   = 2'd0,
      ST_ACCUM   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_OUT     = 2'd3
   } state_t;

   localparam logic [7:0] LAST_COUNT = 8'(KERNEL_LEN - 1);

   state_t             state_r;
   state_t             state_next_s;
   logic [7:0]         count_r;
   logic [7:0]         count_next_s;
   logic               out_valid_r;
   logic               out_valid_next_s;
   logic [7:0]         out_data_r;
   logic [7:0]         out_data_next_s;
   logic               in_ready_s;
   logic               handshake_in_s;
   logic               handshake_out_s;
   logic signed [17:0] sum_s;
   logic signed [17:0] rect_s;
   logic signed [17:0] shifted_s;
   logic [7:0]         result_s;

   function automatic logic [7:0] sat_int8(input logic signed [17:0] value);
      logic [7:0] clipped;
      if (value > 18'sd127) begin
         clipped = 8'h7F;
      end else if (value < -18'sd128) begin
         clipped = 8'h80;
      end else begin
         clipped = value[7:0];
      end
      return clipped;
   endfunction

   // Reset is folded into in_ready so a handshake coinciding with reset never lands.
   assign in_ready_s      = (state_r == ST_ACCUM) && !reset;
   assign handshake_in_s  = in_valid && in_ready_s;
   assign handshake_out_s = out_valid_r && out_ready;

   assign in_ready   = in_ready_s;
   assign mac_data   = in_data;
   assign mac_weight = in_weight;
   assign mac_enable = handshake_in_s;
   assign mac_reset  = reset || (state_r == ST_CLEAR);
   assign out_valid  = out_valid_r;
   assign out_data   = out_data_r;
   assign busy       = (state_r != ST_CLEAR);

   // Post-processing of the captured sum: bias, optional ReLU, floor shift, saturate.
   always_comb begin
      sum_s = $signed({mac_result[16], mac_result}) + $signed({bias[16], bias});
      if ((RELU_EN == 1'b1) && sum_s[17]) begin
         rect_s = 18'sd0;
      end else begin
         rect_s = sum_s;
      end
      shifted_s = rect_s >>> SHIFT;
      result_s  = sat_int8(shifted_s);
   end

   // Next-state and next-register logic for the sequencer.
   always_comb begin
      state_next_s     = state_r;
      count_next_s     = count_r;
      out_valid_next_s = out_valid_r;
      out_data_next_s  = out_data_r;
      case (state_r)
         ST_CLEAR: begin
            count_next_s = 8'd0;
            state_next_s = ST_ACCUM;
         end
         ST_ACCUM: begin
            if (handshake_in_s) begin
               count_next_s = count_r + 8'd1;
               if (count_r == LAST_COUNT) begin
                  state_next_s = ST_CAPTURE;
               end else begin
                  state_next_s = ST_ACCUM;
               end
            end else begin
               state_next_s = ST_ACCUM;
            end
         end
         ST_CAPTURE: begin
            out_data_next_s  = result_s;
            out_valid_next_s = 1'b1;
            state_next_s     = ST_OUT;
         end
         ST_OUT: begin
            if (handshake_out_s) begin
               out_valid_next_s = 1'b0;
               state_next_s     = ST_CLEAR;
            end else begin
               state_next_s = ST_OUT;
            end
         end
         default: begin
            state_next_s     = ST_CLEAR;
            out_valid_next_s = 1'b0;
         end
      endcase
   end

   // State, count and result registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r     <= ST_CLEAR;
         count_r     <= 8'd0;
         out_valid_r <= 1'b0;
         out_data_r  <= 8'd0;
      end else begin
         state_r     <= state_next_s;
         count_r     <= count_next_s;
         out_valid_r <= out_valid_next_s;
         out_data_r  <= out_data_next_s;
      end
   end

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench for mac_sequencer: a ReLU and a linear instance share
// stimulus, each driving its own behavioural 17-bit MAC lane.
module tb_mac_sequencer;

   localparam int K = 9;

   logic        clock = 1'b0;
   logic        reset;
   logic        in_valid;
   logic [7:0]  in_data;
   logic [7:0]  in_weight;
   logic [16:0] bias;
   logic        out_ready;

   logic        r_in_ready, r_mac_enable, r_mac_reset, r_out_valid, r_busy;
   logic [7:0]  r_mac_data, r_mac_weight, r_out_data;
   logic [16:0] r_acc;
   logic        l_in_ready, l_mac_enable, l_mac_reset, l_out_valid, l_busy;
   logic [7:0]  l_mac_data, l_mac_weight, l_out_data;
   logic [16:0] l_acc;

   logic signed [16:0] r_d, r_w, r_prod, l_d, l_w, l_prod;

   int errors = 0;
   int checks = 0;

   always #5 clock = ~clock;

   mac_sequencer #(.KERNEL_LEN(K), .SHIFT(4), .RELU_EN(1'b1)) dut_relu (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(r_in_ready),
      .in_data(in_data), .in_weight(in_weight), .bias(bias),
      .mac_data(r_mac_data), .mac_weight(r_mac_weight), .mac_enable(r_mac_enable),
      .mac_reset(r_mac_reset), .mac_result(r_acc), .out_valid(r_out_valid),
      .out_ready(out_ready), .out_data(r_out_data), .busy(r_busy));

   mac_sequencer #(.KERNEL_LEN(K), .SHIFT(4), .RELU_EN(1'b0)) dut_lin (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(l_in_ready),
      .in_data(in_data), .in_weight(in_weight), .bias(bias),
      .mac_data(l_mac_data), .mac_weight(l_mac_weight), .mac_enable(l_mac_enable),
      .mac_reset(l_mac_reset), .mac_result(l_acc), .out_valid(l_out_valid),
      .out_ready(out_ready), .out_data(l_out_data), .busy(l_busy));

   assign r_d    = {{9{r_mac_data[7]}}, r_mac_data};
   assign r_w    = {{9{r_mac_weight[7]}}, r_mac_weight};
   assign r_prod = r_d * r_w;
   assign l_d    = {{9{l_mac_data[7]}}, l_mac_data};
   assign l_w    = {{9{l_mac_weight[7]}}, l_mac_weight};
   assign l_prod = l_d * l_w;

   // Registered MAC lanes with synchronous clear, wrapping at 17 bits.
   always @(posedge clock) begin
      if (r_mac_reset) r_acc <= 17'd0;
      else if (r_mac_enable) r_acc <= r_acc + r_prod;
      if (l_mac_reset) l_acc <= 17'd0;
      else if (l_mac_enable) l_acc <= l_acc + l_prod;
   end

   // Feed n pairs; at index stall_at hold in_valid low for stall_len cycles.
   task automatic run_kernel(input logic [7:0] d, input logic [7:0] w, input int n,
                             input int stall_at, input int stall_len, output int en_cycles);
      int accepted = 0;
      int stalled = 0;
      int guard = 0;
      en_cycles = 0;
      while (accepted < n && guard < 200) begin
         if (accepted == stall_at && stalled < stall_len) begin
            in_valid = 1'b0;
            #1;
            checks++;
            if (r_mac_enable !== 1'b0 || l_mac_enable !== 1'b0) begin
               errors++;
               $display("FAIL stall_enable: got %b/%b expected 0", r_mac_enable, l_mac_enable);
            end
            stalled++;
         end else begin
            in_valid = 1'b1; in_data = d; in_weight = w;
            #1;
            if (r_mac_enable === 1'b1) en_cycles++;
            if (r_in_ready === 1'b1) accepted++;
         end
         @(posedge clock); #2;
         guard++;
      end
      in_valid = 1'b0;
      if (guard >= 200) begin
         checks++; errors++;
         $display("FAIL kernel_timeout: accepted %0d expected %0d", accepted, n);
      end
   endtask

   // Called two time units after the last accepting edge (CAPTURE cycle).
   task automatic check_result(input string name, input int exp_r, input int exp_l);
      logic [7:0] er, el;
      er = exp_r[7:0];
      el = exp_l[7:0];
      #1;
      checks++;
      if (r_out_valid !== 1'b0 || l_out_valid !== 1'b0 || r_in_ready !== 1'b0) begin
         errors++;
         $display("FAIL %s_capture: out_valid %b/%b in_ready %b expected 0", name, r_out_valid, l_out_valid, r_in_ready);
      end
      @(posedge clock); #2;
      checks++;
      if (r_out_valid !== 1'b1 || l_out_valid !== 1'b1) begin
         errors++;
         $display("FAIL %s_latency: out_valid %b/%b expected 1", name, r_out_valid, l_out_valid);
      end
      checks++;
      if (r_out_data !== er) begin
         errors++;
         $display("FAIL %s_relu: got %0d expected %0d", name, $signed(r_out_data), $signed(er));
      end
      checks++;
      if (l_out_data !== el) begin
         errors++;
         $display("FAIL %s_linear: got %0d expected %0d", name, $signed(l_out_data), $signed(el));
      end
   endtask

   task automatic complete_output(input string name);
      out_ready = 1'b1;
      @(posedge clock); #2;
      out_ready = 1'b0;
      #1;
      checks++;
      if (r_out_valid !== 1'b0 || r_mac_reset !== 1'b1 || r_busy !== 1'b0 || r_in_ready !== 1'b0) begin
         errors++;
         $display("FAIL %s_clear: out_valid %b mac_reset %b busy %b in_ready %b expected 0 1 0 0",
                  name, r_out_valid, r_mac_reset, r_busy, r_in_ready);
      end
      @(posedge clock); #3;
      checks++;
      if (r_in_ready !== 1'b1 || l_in_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s_rearm: in_ready %b/%b expected 1", name, r_in_ready, l_in_ready);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b0; in_data = 8'd0; in_weight = 8'd0;
      bias = 17'd0; out_ready = 1'b0;
      repeat (3) @(posedge clock);
      #2;
      checks++;
      if (r_mac_reset !== 1'b1 || r_out_valid !== 1'b0 || r_out_data !== 8'd0 ||
          r_in_ready !== 1'b0 || r_busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: mac_reset %b out_valid %b out_data %0d in_ready %b busy %b expected 1 0 0 0 0",
                  r_mac_reset, r_out_valid, r_out_data, r_in_ready, r_busy);
      end
      reset = 1'b0;
   endtask

   task automatic test_basic();
      int en;
      bias = 17'd0;
      run_kernel(8'd10, 8'd3, K, -1, 0, en);
      checks++;
      if (en !== K) begin
         errors++;
         $display("FAIL basic_enable_cycles: got %0d expected %0d", en, K);
      end
      check_result("basic", 16, 16);
      complete_output("basic");
      in_data = 8'h5A; in_weight = 8'hC3;
      #1;
      checks++;
      if (r_mac_data !== 8'h5A || r_mac_weight !== 8'hC3) begin
         errors++;
         $display("FAIL passthrough: got %h/%h expected 5a/c3", r_mac_data, r_mac_weight);
      end
   endtask

   task automatic test_negative();
      int en;
      run_kernel(8'd10, 8'hFD, K, -1, 0, en);
      check_result("negative", 0, -17);
      complete_output("negative");
   endtask

   task automatic test_saturation();
      int en;
      run_kernel(8'd100, 8'd20, K, -1, 0, en);
      check_result("sat_pos", 127, 127);
      complete_output("sat_pos");
      run_kernel(8'd100, 8'hEC, K, -1, 0, en);
      check_result("sat_neg", 0, -128);
      complete_output("sat_neg");
   endtask

   task automatic test_bias_stall();
      int en;
      bias = 17'h1FF92;
      run_kernel(8'd10, 8'd3, K, 4, 5, en);
      checks++;
      if (en !== K) begin
         errors++;
         $display("FAIL stall_enable_cycles: got %0d expected %0d", en, K);
      end
      check_result("bias_stall", 10, 10);
      complete_output("bias_stall");
      bias = 17'd0;
   endtask

   task automatic test_backpressure();
      int en;
      run_kernel(8'd10, 8'd3, K, -1, 0, en);
      check_result("bp", 16, 16);
      for (int i = 0; i < 10; i++) begin
         @(posedge clock); #3;
         checks++;
         if (r_out_valid !== 1'b1 || r_out_data !== 8'd16 || r_in_ready !== 1'b0 || r_busy !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold: out_valid %b out_data %0d in_ready %b busy %b expected 1 16 0 1",
                     r_out_valid, r_out_data, r_in_ready, r_busy);
         end
      end
      complete_output("bp");
   endtask

   task automatic test_mid_reset();
      int en;
      run_kernel(8'd10, 8'd3, 5, -1, 0, en);
      in_valid = 1'b1; reset = 1'b1;
      #1;
      checks++;
      if (r_mac_reset !== 1'b1 || r_mac_enable !== 1'b0) begin
         errors++;
         $display("FAIL midreset_mac: mac_reset %b mac_enable %b expected 1 0", r_mac_reset, r_mac_enable);
      end
      @(posedge clock); #2;
      reset = 1'b0; in_valid = 1'b0;
      #1;
      checks++;
      if (r_out_valid !== 1'b0 || r_busy !== 1'b0 || r_acc !== 17'd0) begin
         errors++;
         $display("FAIL midreset_state: out_valid %b busy %b acc %0d expected 0 0 0", r_out_valid, r_busy, r_acc);
      end
      run_kernel(8'd10, 8'd3, K, -1, 0, en);
      check_result("after_reset", 16, 16);
      reset = 1'b1;
      @(posedge clock); #2;
      reset = 1'b0;
      checks++;
      if (r_out_valid !== 1'b0 || l_out_valid !== 1'b0) begin
         errors++;
         $display("FAIL out_reset: out_valid %b/%b expected 0", r_out_valid, l_out_valid);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_negative();
      test_saturation();
      test_bias_stall();
      test_backpressure();
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

endmodule
